// File: rtl/mc_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | mc_ctrl_if : datapath bus between the multi-cycle control unit and datapath
// | Revision   : 1.0 - initial release
// +----------------------------------------------------------------------------
interface mc_ctrl_if;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       PCWrite;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemtoReg;
   logic       RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] PCSource;

   // The controller drives the control lines; the datapath returns status.
   modport master (
      input  opcode, zero, mem_ready,
      output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
             RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
             RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
   );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | mc_ctrl  : multi-cycle MIPS control FSM with memory stall, timeout and
// |            retired-instruction counter. Optional bne via MC_CTRL_BNE_EN.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
module mc_ctrl #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             halt,
   mc_ctrl_if.master        bus,
   output logic             busy,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam int         c_WAIT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [5:0] c_OP_RTYPE = 6'h00;
   localparam logic [5:0] c_OP_LW    = 6'h23;
   localparam logic [5:0] c_OP_SW    = 6'h2B;
   localparam logic [5:0] c_OP_BEQ   = 6'h04;
   localparam logic [5:0] c_OP_J     = 6'h02;
   localparam logic [5:0] c_OP_ADDI  = 6'h08;
`ifdef MC_CTRL_BNE_EN
   localparam logic [5:0] c_OP_BNE   = 6'h05;
`endif
   localparam logic [1:0] c_ERR_NONE = 2'b00;
   localparam logic [1:0] c_ERR_ILL  = 2'b01;
   localparam logic [1:0] c_ERR_TMO  = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_RWB    = 4'd8,
      S_IEXEC  = 4'd9,
      S_IWB    = 4'd10,
      S_BRANCH = 4'd11,
      S_JUMP   = 4'd12,
      S_ERR    = 4'd13
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [1:0]          r_err;
   logic [CNT_W-1:0]    r_cnt;
   logic [c_WAIT_W-1:0] r_wait;
   logic                w_in_mem;
   logic                w_timeout;
   logic                w_final;
   logic                w_set_err;
   logic [1:0]          w_err_val;
   logic                w_br_take;

   assign w_in_mem  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
   assign w_timeout = w_in_mem && !bus.mem_ready && (r_wait == c_WAIT_W'(MAX_WAIT));

`ifdef MC_CTRL_BNE_EN
   logic r_is_bne;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_is_bne <= 1'b0;
      else if (r_state == S_DECODE)
         r_is_bne <= (bus.opcode == c_OP_BNE);
   end

   assign w_br_take = r_is_bne ? ~bus.zero : bus.zero;
`else
   assign w_br_take = bus.zero;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_err   <= c_ERR_NONE;
         r_cnt   <= '0;
         r_wait  <= '0;
      end else begin
         r_state <= w_next;
         if (w_set_err)
            r_err <= w_err_val;
         if (w_final)
            r_cnt <= r_cnt + 1'b1;
         // Any stay in a memory state is a low mem_ready cycle; anything else restarts the count.
         if (w_in_mem && !bus.mem_ready && (w_next == r_state))
            r_wait <= r_wait + 1'b1;
         else
            r_wait <= '0;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_final      = 1'b0;
      w_set_err    = 1'b0;
      w_err_val    = c_ERR_NONE;
      bus.PCWrite  = 1'b0;
      bus.IorD     = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.MemtoReg = 1'b0;
      bus.RegDst   = 1'b0;
      bus.RegWrite = 1'b0;
      bus.ALUSrcA  = 1'b0;
      bus.ALUSrcB  = 2'b00;
      bus.ALUOp    = 2'b00;
      bus.PCSource = 2'b00;
      case (r_state)
         S_IDLE: begin
            if (start)
               w_next = S_FETCH;
         end
         S_FETCH: begin
            bus.MemRead = 1'b1;
            bus.ALUSrcB = 2'b01;
            if (bus.mem_ready) begin
               bus.IRWrite = 1'b1;
               bus.PCWrite = 1'b1;
               w_next      = S_DECODE;
            end else if (w_timeout) begin
               w_next    = S_ERR;
               w_set_err = 1'b1;
               w_err_val = c_ERR_TMO;
            end
         end
         S_DECODE: begin
            bus.ALUSrcB = 2'b11;
            case (bus.opcode)
               c_OP_RTYPE:        w_next = S_EXEC;
               c_OP_LW, c_OP_SW:  w_next = S_MEMADR;
               c_OP_BEQ:          w_next = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
               c_OP_BNE:          w_next = S_BRANCH;
`endif
               c_OP_J:            w_next = S_JUMP;
               c_OP_ADDI:         w_next = S_IEXEC;
               default: begin
                  w_next    = S_ERR;
                  w_set_err = 1'b1;
                  w_err_val = c_ERR_ILL;
               end
            endcase
         end
         S_MEMADR: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            w_next      = (bus.opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            bus.MemRead = 1'b1;
            bus.IorD    = 1'b1;
            if (bus.mem_ready) begin
               w_next = S_MEMWB;
            end else if (w_timeout) begin
               w_next    = S_ERR;
               w_set_err = 1'b1;
               w_err_val = c_ERR_TMO;
            end
         end
         S_MEMWB: begin
            bus.RegWrite = 1'b1;
            bus.MemtoReg = 1'b1;
            w_final      = 1'b1;
         end
         S_MEMWR: begin
            bus.MemWrite = 1'b1;
            bus.IorD     = 1'b1;
            if (bus.mem_ready) begin
               w_final = 1'b1;
            end else if (w_timeout) begin
               w_next    = S_ERR;
               w_set_err = 1'b1;
               w_err_val = c_ERR_TMO;
            end
         end
         S_EXEC: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUOp   = 2'b10;
            w_next      = S_RWB;
         end
         S_RWB: begin
            bus.RegWrite = 1'b1;
            bus.RegDst   = 1'b1;
            w_final      = 1'b1;
         end
         S_IEXEC: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            w_next      = S_IWB;
         end
         S_IWB: begin
            bus.RegWrite = 1'b1;
            w_final      = 1'b1;
         end
         S_BRANCH: begin
            bus.ALUSrcA  = 1'b1;
            bus.ALUOp    = 2'b01;
            bus.PCSource = 2'b01;
            bus.PCWrite  = w_br_take;
            w_final      = 1'b1;
         end
         S_JUMP: begin
            bus.PCWrite  = 1'b1;
            bus.PCSource = 2'b10;
            w_final      = 1'b1;
         end
         S_ERR: begin
            w_next = S_ERR;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
      if (w_final)
         w_next = halt ? S_IDLE : S_FETCH;
   end

   assign busy      = (r_state != S_IDLE) && (r_state != S_ERR);
   assign err_code  = r_err;
   assign instr_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_mc_ctrl : randomized scoreboard bench for mc_ctrl (default build, no bne)
// | Revision   : 1.0 - initial release
// +----------------------------------------------------------------------------
module tb_mc_ctrl;
   localparam int MAX_WAIT = 15;
   localparam int CNT_W    = 3;
   localparam int NS       = 17;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             halt;
   logic             busy;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] instr_cnt;

   mc_ctrl_if bus ();

   mc_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .halt      (halt),
      .bus       (bus),
      .busy      (busy),
      .err_code  (err_code),
      .instr_cnt (instr_cnt)
   );

   always #5 clk = ~clk;

   // Per-instruction summary: how many cycles each observed condition held, plus end status.
   typedef struct packed {
      logic [NS-1:0][7:0] c;
      logic [1:0]         err;
      logic [CNT_W-1:0]   cnt;
      logic               busy_after;
   } exp_t;

   exp_t             exp_q[$];
   int               wait_q[$];
   int               n_cmp = 0;
   int               n_bad = 0;
   logic [CNT_W-1:0] m_cnt;
   bit               m_idle;

   task automatic check(string name, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail(string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   function automatic string sig_name(int i);
      case (i)
         0:  return "busy_cycles";
         1:  return "IRWrite_cycles";
         2:  return "PCWrite_cycles";
         3:  return "RegWrite_cycles";
         4:  return "MemWrite_cycles";
         5:  return "MemRead_cycles";
         6:  return "IorD_cycles";
         7:  return "ALUSrcA_cycles";
         8:  return "RegDst_cycles";
         9:  return "MemtoReg_cycles";
         10: return "ALUOp_sub_cycles";
         11: return "ALUOp_funct_cycles";
         12: return "ALUSrcB_11_cycles";
         13: return "ALUSrcB_10_cycles";
         14: return "PCSource_jump_cycles";
         15: return "PCSource_aluout_cycles";
         16: return "ALUSrcB_01_cycles";
         default: return "unknown";
      endcase
   endfunction

   function automatic int obs(int i);
      case (i)
         0:  return int'(busy);
         1:  return int'(bus.IRWrite);
         2:  return int'(bus.PCWrite);
         3:  return int'(bus.RegWrite);
         4:  return int'(bus.MemWrite);
         5:  return int'(bus.MemRead);
         6:  return int'(bus.IorD);
         7:  return int'(bus.ALUSrcA);
         8:  return int'(bus.RegDst);
         9:  return int'(bus.MemtoReg);
         10: return int'(bus.ALUOp == 2'b01);
         11: return int'(bus.ALUOp == 2'b10);
         12: return int'(bus.ALUSrcB == 2'b11);
         13: return int'(bus.ALUSrcB == 2'b10);
         14: return int'(bus.PCSource == 2'b10);
         15: return int'(bus.PCSource == 2'b01);
         16: return int'(bus.ALUSrcB == 2'b01);
         default: return 0;
      endcase
   endfunction

   function automatic int ctrl_vec();
      return int'({bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                   bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                   bus.ALUSrcB, bus.ALUOp, bus.PCSource});
   endfunction

   // Instruction-level reference: phases and their lengths from the ISA rules.
   function automatic exp_t model(logic [5:0] op, bit z, bit h, int fw, int mw,
                                  logic [CNT_W-1:0] cnt_in);
      exp_t e;
      int   k[NS];
      int   n;
      bit   ret;
      e   = '0;
      ret = 1'b0;
      for (int i = 0; i < NS; i++) k[i] = 0;
      if (fw > MAX_WAIT) begin
         k[0]  = MAX_WAIT + 1;
         k[5]  = MAX_WAIT + 1;
         k[16] = MAX_WAIT + 1;
         e.err = 2'b10;
      end else begin
         k[0]  = fw + 2;
         k[5]  = fw + 1;
         k[16] = fw + 1;
         k[1]  = 1;
         k[2]  = 1;
         k[12] = 1;
         case (op)
            6'h00: begin k[0] += 2; k[7]++; k[11]++; k[3]++; k[8]++; ret = 1'b1; end
            6'h08: begin k[0] += 2; k[7]++; k[13]++; k[3]++; ret = 1'b1; end
            6'h04: begin k[0] += 1; k[7]++; k[10]++; k[15]++; k[2] += int'(z); ret = 1'b1; end
            6'h02: begin k[0] += 1; k[2]++; k[14]++; ret = 1'b1; end
            6'h23, 6'h2B: begin
               k[0] += 1; k[7]++; k[13]++;
               n = (mw > MAX_WAIT) ? MAX_WAIT + 1 : mw + 1;
               k[0] += n;
               k[6] += n;
               if (op == 6'h23) k[5] += n;
               else             k[4] += n;
               if (mw > MAX_WAIT) begin
                  e.err = 2'b10;
               end else begin
                  ret = 1'b1;
                  if (op == 6'h23) begin k[0]++; k[3]++; k[9]++; end
               end
            end
            default: e.err = 2'b01;
         endcase
      end
      for (int i = 0; i < NS; i++) e.c[i] = 8'(k[i]);
      e.cnt        = ret ? cnt_in + 1'b1 : cnt_in;
      e.busy_after = ret && !h;
      return e;
   endfunction

   // Memory: answers each request after the queued number of low cycles.
   initial begin : memory
      int lows;
      bit in_acc;
      lows          = 0;
      in_acc        = 1'b0;
      bus.mem_ready = 1'b0;
      forever begin
         @(posedge clk);
         #3;
         if (!rst || !(bus.MemRead || bus.MemWrite)) begin
            in_acc        = 1'b0;
            bus.mem_ready = 1'b0;
         end else begin
            if (!in_acc) begin
               in_acc = 1'b1;
               lows   = 0;
               if (wait_q.size() > 0) lows = wait_q.pop_front();
            end
            if (lows > 0) begin
               lows--;
               bus.mem_ready = 1'b0;
            end else begin
               bus.mem_ready = 1'b1;
               in_acc        = 1'b0;
            end
         end
      end
   end

   // Monitor: a retire or error entry closes one instruction's observation window.
   initial begin : monitor
      int               acc[NS];
      logic [CNT_W-1:0] prev_cnt;
      bit               err_seen;
      exp_t             e;
      prev_cnt = '0;
      err_seen = 1'b0;
      for (int i = 0; i < NS; i++) acc[i] = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_cnt = '0;
            err_seen = 1'b0;
            for (int i = 0; i < NS; i++) acc[i] = 0;
         end else begin
            if ((instr_cnt != prev_cnt) || (!busy && err_code != 2'b00 && !err_seen)) begin
               if (exp_q.size() == 0) begin
                  fail("unexpected_completion");
               end else begin
                  e = exp_q.pop_front();
                  for (int i = 0; i < NS; i++) check(sig_name(i), acc[i], int'(e.c[i]));
                  check("err_code", int'(err_code), int'(e.err));
                  check("instr_cnt", int'(instr_cnt), int'(e.cnt));
                  check("busy_after", int'(busy), int'(e.busy_after));
               end
               prev_cnt = instr_cnt;
               if (!busy && err_code != 2'b00) err_seen = 1'b1;
               for (int i = 0; i < NS; i++) acc[i] = 0;
            end
            for (int i = 0; i < NS; i++) acc[i] += obs(i);
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_instr_cnt", int'(instr_cnt), 0);
      check("rst_err_code", int'(err_code), 0);
      check("rst_controls", ctrl_vec(), 0);
      @(posedge clk);
      #2;
      exp_q.delete();
      wait_q.delete();
      @(posedge clk);
      #2;
      rst    = 1'b1;
      m_cnt  = '0;
      m_idle = 1'b1;
   endtask

   task automatic recover(logic [1:0] er);
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("err_hold_busy", int'(busy), 0);
      check("err_hold_code", int'(err_code), int'(er));
      check("err_hold_controls", ctrl_vec(), 0);
      do_reset();
   endtask

   task automatic run_instr(logic [5:0] op, bit z, bit h, int fw, int mw);
      exp_t             e;
      logic [CNT_W-1:0] c0;
      bit               done;
      e = model(op, z, h, fw, mw, m_cnt);
      exp_q.push_back(e);
      wait_q.push_back(fw);
      if ((op == 6'h23 || op == 6'h2B) && fw <= MAX_WAIT) wait_q.push_back(mw);
      bus.opcode = op;
      bus.zero   = z;
      halt       = h;
      c0         = instr_cnt;
      if (m_idle) begin
         start = 1'b1;
         @(posedge clk);
         #2;
         start = 1'b0;
      end
      done = 1'b0;
      for (int t = 0; t < 200 && !done; t++) begin
         @(posedge clk);
         #2;
         if (instr_cnt != c0 || (!busy && err_code != 2'b00)) done = 1'b1;
      end
      if (!done) fail("instruction_never_completed");
      m_cnt  = e.cnt;
      m_idle = !e.busy_after;
      if (e.err != 2'b00) recover(e.err);
   endtask

   task automatic mid_fetch_reset();
      wait_q.push_back(8);
      bus.opcode = 6'h00;
      halt       = 1'b0;
      start      = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      check("start_to_fetch_busy", int'(busy), 1);
      check("start_to_fetch_memread", int'(bus.MemRead), 1);
      check("count_before_reset", int'(instr_cnt), int'(m_cnt));
      repeat (2) @(posedge clk);
      #2;
      do_reset();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst        = 1'b0;
      start      = 1'b0;
      halt       = 1'b0;
      bus.opcode = 6'h00;
      bus.zero   = 1'b0;
      m_cnt      = '0;
      m_idle     = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      check("init_busy", int'(busy), 0);
      check("init_instr_cnt", int'(instr_cnt), 0);
      check("init_err_code", int'(err_code), 0);
      check("init_controls", ctrl_vec(), 0);
      rst = 1'b1;

      // add / lw / sw / beq taken / j with halt
      run_instr(6'h00, 1'b0, 1'b0, 0, 0);
      run_instr(6'h23, 1'b0, 1'b0, 0, 0);
      run_instr(6'h2B, 1'b0, 1'b0, 0, 0);
      run_instr(6'h04, 1'b1, 1'b0, 0, 0);
      run_instr(6'h02, 1'b0, 1'b1, 0, 0);
      repeat (2) @(posedge clk);
      #2;
      check("idle_after_halt", int'(busy), 0);
      mid_fetch_reset();

      run_instr(6'h23, 1'b0, 1'b0, 0, 3);
      run_instr(6'h23, 1'b0, 1'b0, 15, 15);
      run_instr(6'h2B, 1'b0, 1'b0, 2, 15);
      run_instr(6'h04, 1'b0, 1'b0, 1, 0);
      run_instr(6'h08, 1'b0, 1'b1, 0, 0);
      run_instr(6'h05, 1'b0, 1'b0, 0, 0);
      run_instr(6'h3F, 1'b0, 1'b0, 0, 0);
      run_instr(6'h00, 1'b0, 1'b0, 16, 0);
      run_instr(6'h23, 1'b0, 1'b0, 0, 16);
      run_instr(6'h2B, 1'b0, 1'b0, 1, 16);

      for (int n = 0; n < 80; n++) begin
         int         r;
         int         fw;
         int         mw;
         logic [5:0] op;
         r = $urandom_range(0, 99);
         if      (r < 18) op = 6'h00;
         else if (r < 34) op = 6'h23;
         else if (r < 50) op = 6'h2B;
         else if (r < 66) op = 6'h04;
         else if (r < 80) op = 6'h02;
         else if (r < 96) op = 6'h08;
         else             op = 6'($urandom_range(0, 63));
         r  = $urandom_range(0, 99);
         fw = (r < 60) ? 0 : (r < 98) ? $urandom_range(1, 5) : 16;
         r  = $urandom_range(0, 99);
         mw = (r < 50) ? 0 : (r < 97) ? $urandom_range(1, 6) : 16;
         run_instr(op, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 15), fw, mw);
      end

      repeat (3) @(posedge clk);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
